sram_bank_ctrl: RTL and testbench

- Sits directly downstream of the AXI4-to-SRAM memory controller and consumes its single-port SRAM request stream: active-low enable, write enable and bit mask; word address; write data.
- Splits the word address space across BANK_NUM physical single-port macros.
- Returns read data one cycle after the request, using a registered bank select.
- Owns a zero-initialisation sequencer that clears every word after reset or on request; busy_o tells the top level to hold AXI AR/AW valid low until clearing finishes.

---
 rtl/sram_bank_pkg.sv | 17 +
 rtl/sram_init_seq.sv | 50 +++++
 rtl/sram_bank_ctrl.sv | 96 +++++++++
 tb/tb_sram_bank_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_pkg.sv
// rtl/sram_bank_pkg.sv - shared types, default sizes and helpers for the SRAM bank controller
package sram_bank_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 13;
   localparam int DEF_BANK_NUM   = 4;

   function automatic int bank_idx_w(input int bank_num);
      return (bank_num > 1) ? $clog2(bank_num) : 1;
   endfunction

endpackage

// File: rtl/sram_init_seq.sv
// rtl/sram_init_seq.sv - INIT/RUN sequencer that walks every macro word once for zero-fill
module sram_init_seq
   import sram_bank_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          init_req_i,
   output logic          busy_o,
   output logic [AW-1:0] cnt_o
);

   localparam logic [AW-1:0] CNT_LAST = '1;

   state_t        r_state;
   logic [AW-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= INIT;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            INIT: begin
               if (r_cnt == CNT_LAST) begin
                  r_state <= RUN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RUN: begin
               if (init_req_i) begin
                  r_state <= INIT;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= INIT;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign busy_o = (r_state == INIT);
   assign cnt_o  = r_cnt;

endmodule

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - splits a single-port SRAM request stream over BANK_NUM macros with zero-init
module sram_bank_ctrl
   import sram_bank_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter  int BANK_NUM   = DEF_BANK_NUM,
   localparam int BANK_IW    = bank_idx_w(BANK_NUM),
   localparam int BANK_AW    = ADDR_WIDTH - BANK_IW
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   input  logic                           wen_i,
   input  logic [DATA_WIDTH-1:0]          bm_i,
   input  logic [ADDR_WIDTH-1:0]          addr_i,
   input  logic [DATA_WIDTH-1:0]          dat_i,
   output logic [DATA_WIDTH-1:0]          dat_o,
   input  logic                           init_req_i,
   output logic                           busy_o,
   output logic                           err_o,
   input  logic                           err_clr_i,
   output logic [BANK_NUM-1:0]            bank_en_o,
   output logic                           bank_wen_o,
   output logic [DATA_WIDTH-1:0]          bank_bm_o,
   output logic [BANK_AW-1:0]             bank_addr_o,
   output logic [DATA_WIDTH-1:0]          bank_dat_o,
   input  logic [BANK_NUM*DATA_WIDTH-1:0] bank_rdata_i
);

   logic               w_busy;
   logic [BANK_AW-1:0] w_init_addr;
   logic [BANK_IW-1:0] w_bank_idx;
   logic               w_rd_req;
   logic [BANK_IW-1:0] r_rd_sel;
   logic               r_err;

   sram_init_seq #(
      .AW(BANK_AW)
   ) u_init_seq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .init_req_i (init_req_i),
      .busy_o     (w_busy),
      .cnt_o      (w_init_addr)
   );

   // Contiguous mapping: the top address bits pick the macro.
   assign w_bank_idx = addr_i[ADDR_WIDTH-1 -: BANK_IW];
   assign w_rd_req   = ~w_busy & ~en_i & wen_i;

   always_comb begin
      bank_en_o   = '1;
      bank_wen_o  = 1'b1;
      bank_bm_o   = '1;
      bank_addr_o = '0;
      bank_dat_o  = '0;
      if (w_busy) begin
         bank_en_o   = '0;
         bank_wen_o  = 1'b0;
         bank_bm_o   = '0;
         bank_addr_o = w_init_addr;
         bank_dat_o  = '0;
      end else begin
         for (int k = 0; k < BANK_NUM; k++) begin
            bank_en_o[k] = en_i | (BANK_IW'(k) != w_bank_idx);
         end
         bank_wen_o  = wen_i;
         bank_bm_o   = bm_i;
         bank_addr_o = addr_i[BANK_AW-1:0];
         bank_dat_o  = dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_sel <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_rd_req) begin
            r_rd_sel <= w_bank_idx;
         end
         // A new error in the same cycle as a clear keeps the flag set.
         if (w_busy & ~en_i) begin
            r_err <= 1'b1;
         end else if (err_clr_i) begin
            r_err <= 1'b0;
         end
      end
   end

   assign dat_o  = bank_rdata_i[r_rd_sel*DATA_WIDTH +: DATA_WIDTH];
   assign busy_o = w_busy;
   assign err_o  = r_err;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - randomized self-checking bench for sram_bank_ctrl with macro and reference models
module tb_sram_bank_ctrl;

   localparam int DW    = 64;
   localparam int AW    = 13;
   localparam int BN    = 4;
   localparam int BAW   = 11;
   localparam int DEPTH = 2048;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            en_i;
   logic            wen_i;
   logic [DW-1:0]   bm_i;
   logic [AW-1:0]   addr_i;
   logic [DW-1:0]   dat_i;
   logic [DW-1:0]   dat_o;
   logic            init_req_i;
   logic            busy_o;
   logic            err_o;
   logic            err_clr_i;
   logic [BN-1:0]   bank_en_o;
   logic            bank_wen_o;
   logic [DW-1:0]   bank_bm_o;
   logic [BAW-1:0]  bank_addr_o;
   logic [DW-1:0]   bank_dat_o;
   logic [BN*DW-1:0] bank_rdata_i;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sram_bank_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .en_i         (en_i),
      .wen_i        (wen_i),
      .bm_i         (bm_i),
      .addr_i       (addr_i),
      .dat_i        (dat_i),
      .dat_o        (dat_o),
      .init_req_i   (init_req_i),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .err_clr_i    (err_clr_i),
      .bank_en_o    (bank_en_o),
      .bank_wen_o   (bank_wen_o),
      .bank_bm_o    (bank_bm_o),
      .bank_addr_o  (bank_addr_o),
      .bank_dat_o   (bank_dat_o),
      .bank_rdata_i (bank_rdata_i)
   );

   function automatic logic [DW-1:0] seed(input int i);
      return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'h5A5A_1234};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural single-port macros with masked writes and held read output.
   logic [DW-1:0] mac_mem [BN][DEPTH];
   logic [DW-1:0] mac_q   [BN];
   assign bank_rdata_i = {mac_q[3], mac_q[2], mac_q[1], mac_q[0]};

   initial begin
      for (int k = 0; k < BN; k++) begin
         mac_q[k] <= '0;
         for (int j = 0; j < DEPTH; j++) mac_mem[k][j] <= seed(k*DEPTH + j);
      end
      forever begin
         @(posedge clk);
         for (int k = 0; k < BN; k++) begin
            if (bank_en_o[k] === 1'b0) begin
               if (bank_wen_o === 1'b0)
                  mac_mem[k][bank_addr_o] <= (mac_mem[k][bank_addr_o] & bank_bm_o) | (bank_dat_o & ~bank_bm_o);
               else
                  mac_q[k] <= mac_mem[k][bank_addr_o];
            end
         end
      end
   end

   // Reference model: flat word memory, init progress, error flag, last read per bank.
   logic [DW-1:0] ref_mem  [BN*DEPTH];
   logic [DW-1:0] ref_last [BN];
   bit m_valid = 0;
   bit m_busy  = 1;
   int m_pos   = 0;
   bit m_err   = 0;
   int m_sel   = 0;

   initial begin
      int a;
      for (int i = 0; i < BN*DEPTH; i++) ref_mem[i] = seed(i);
      for (int k = 0; k < BN; k++) ref_last[k] = '0;
      forever begin
         @(posedge clk);
         a = int'(addr_i);
         if (!m_valid) begin
            if (rst_i) begin
               m_valid = 1; m_busy = 1; m_pos = 0; m_err = 0; m_sel = 0;
            end
         end else begin
            if (m_busy) begin
               for (int k = 0; k < BN; k++) ref_mem[k*DEPTH + m_pos] = '0;
            end else if (!en_i) begin
               if (!wen_i) ref_mem[a] = (ref_mem[a] & bm_i) | (dat_i & ~bm_i);
               else        ref_last[a / DEPTH] = ref_mem[a];
            end
            if (rst_i) begin
               m_busy = 1; m_pos = 0; m_err = 0; m_sel = 0;
            end else if (m_busy) begin
               if (!en_i) m_err = 1;
               else if (err_clr_i) m_err = 0;
               if (m_pos == DEPTH-1) begin m_busy = 0; m_pos = 0; end
               else m_pos++;
            end else begin
               if (err_clr_i) m_err = 0;
               if (!en_i && wen_i) m_sel = a / DEPTH;
               if (init_req_i) begin m_busy = 1; m_pos = 0; end
            end
         end
      end
   end

   // Per-cycle comparison on the falling edge.
   initial begin
      logic [BN-1:0] e_en;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("busy", 64'(busy_o), 64'(m_busy));
            chk("err", 64'(err_o), 64'(m_err));
            chk("dat_o", dat_o, ref_last[m_sel]);
            if (m_busy) begin
               chk("init_en", 64'(bank_en_o), 64'(0));
               chk("init_wen", 64'(bank_wen_o), 64'(0));
               chk("init_bm", bank_bm_o, 64'(0));
               chk("init_dat", bank_dat_o, 64'(0));
               chk("init_addr", 64'(bank_addr_o), 64'(m_pos));
            end else begin
               for (int k = 0; k < BN; k++) e_en[k] = !(en_i == 1'b0 && int'(addr_i) / DEPTH == k);
               chk("run_en", 64'(bank_en_o), 64'(e_en));
               chk("run_wen", 64'(bank_wen_o), 64'(wen_i));
               chk("run_bm", bank_bm_o, bm_i);
               chk("run_dat", bank_dat_o, dat_i);
               chk("run_addr", 64'(bank_addr_o), 64'(int'(addr_i) % DEPTH));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en_i = 1'b1; wen_i = 1'b1; bm_i = '1; err_clr_i = 1'b0; init_req_i = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
      en_i = 1'b0; wen_i = 1'b0; addr_i = a; dat_i = d; bm_i = m;
      step();
      idle();
   endtask

   task automatic rd(input logic [AW-1:0] a);
      en_i = 1'b0; wen_i = 1'b1; addr_i = a;
      step();
      idle();
   endtask

   task automatic wait_busy(input string name);
      int n;
      n = 0;
      while (busy_o === 1'b1 && n < 5000) begin
         n++;
         step();
      end
      chk(name, 64'(n), 64'(DEPTH));
   endtask

   initial begin
      int n;
      logic [DW-1:0] w [4];
      logic [AW-1:0] ra [4];
      rst_i = 1'b1; addr_i = '0; dat_i = '0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      chk("busy_after_reset", 64'(busy_o), 64'(1));
      chk("addr_after_reset", 64'(bank_addr_o), 64'(0));

      // Initial zero-fill with a stray read request at cycle 10.
      n = 0;
      while (busy_o === 1'b1 && n < 5000) begin
         if (n == 10) begin en_i = 1'b0; wen_i = 1'b1; addr_i = 13'h0ABC; end
         if (n == 11) idle();
         if (n == 12) chk("err_set", 64'(err_o), 64'(1));
         n++;
         step();
      end
      chk("init_len", 64'(n), 64'(DEPTH));
      chk("err_sticky", 64'(err_o), 64'(1));
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      chk("err_cleared", 64'(err_o), 64'(0));

      rd(13'h0ABC);
      chk("zero_after_init", dat_o, 64'(0));

      en_i = 1'b0; wen_i = 1'b0; addr_i = 13'h1800; dat_i = 64'h1122334455667788; bm_i = '0;
      #1;
      chk("wr_bank3_en", 64'(bank_en_o), 64'(4'b0111));
      chk("wr_bank3_addr", 64'(bank_addr_o), 64'(0));
      step();
      en_i = 1'b0; wen_i = 1'b1; bm_i = '1;
      #1;
      chk("rd_bank3_en", 64'(bank_en_o), 64'(4'b0111));
      step();
      idle();
      chk("rd_bank3_data", dat_o, 64'h1122334455667788);

      wr(13'h0005, 64'hAAAAAAAABBBBBBBB, 64'hFFFFFFFF00000000);
      rd(13'h0005);
      chk("masked_write", dat_o, 64'h00000000BBBBBBBB);

      ra[0] = 13'h0001; ra[1] = 13'h0801; ra[2] = 13'h1001; ra[3] = 13'h1801;
      for (int i = 0; i < 4; i++) begin
         w[i] = 64'hC0DE_0000_0000_0000 | 64'(i + 1);
         wr(ra[i], w[i], '0);
      end
      for (int i = 0; i < 4; i++) begin
         en_i = 1'b0; wen_i = 1'b1; addr_i = ra[i];
         step();
         chk("b2b_read", dat_o, w[i]);
      end
      idle();
      repeat (3) begin
         step();
         chk("hold_bank3", dat_o, w[3]);
      end

      for (int i = 0; i < 800; i++) begin
         addr_i = AW'($urandom_range(0, 3) * DEPTH + $urandom_range(0, 7));
         dat_i  = {$urandom, $urandom};
         bm_i   = ($urandom_range(0, 1) == 0) ? '0 : {$urandom, $urandom};
         err_clr_i = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 2))
            0: begin en_i = 1'b0; wen_i = 1'b0; end
            1: begin en_i = 1'b0; wen_i = 1'b1; end
            default: begin en_i = 1'b1; wen_i = $urandom_range(0, 1) == 1; end
         endcase
         step();
      end
      idle();

      wr(13'h0010, 64'hDEAD, '0);
      rd(13'h0010);
      chk("dead_written", dat_o, 64'hDEAD);
      init_req_i = 1'b1;
      step();
      init_req_i = 1'b0;
      wait_busy("reinit_len");
      rd(13'h0010);
      chk("dead_cleared", dat_o, 64'(0));

      init_req_i = 1'b1;
      step();
      init_req_i = 1'b0;
      repeat (1000) step();
      chk("init_addr_1000", 64'(bank_addr_o), 64'(1000));
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("restart_addr", 64'(bank_addr_o), 64'(0));
      wait_busy("restart_len");
      chk("err_after_restart", 64'(err_o), 64'(0));

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
